// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared constants for the streaming pipelined ALU.
//   - opcode width and opcode encodings (OP_ADD .. OP_PASS)
//   - bit positions of the {N, Z, C, V} status flags in the 4-bit flags word
package alu_pipe_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: one valid/data slot of an elastic pipeline.
//   clk, reset      : clock, synchronous active-low reset
//   up_valid/up_data: candidate entry from the previous slot (or the ALU)
//   ready           : this slot takes up_data at the next edge if up_valid
//   down_ready      : next slot (or consumer) takes this slot's entry
//   valid/data      : slot contents
// A slot loads whenever it is empty or its own entry is leaving, so empty
// slots fill even while the consumer stalls (bubble collapsing).
module alu_pipe_stage #(
    parameter int PW       = 8,
    parameter bit ZERO_RST = 1'b0   // clear data at reset (used by the output slot)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    output logic          ready,
    input  logic          down_ready,
    output logic          valid,
    output logic [PW-1:0] data
);

    assign ready = !valid || down_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            if (ZERO_RST) begin
                data <= '0;
            end
        end else if (ready) begin
            valid <= up_valid;
            // Only capture real entries so a drained output slot keeps its
            // last (or reset) value instead of picking up garbage.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/alu_pipe_stream.sv
// alu_pipe_stream: 8-op ALU with status flags followed by a STAGES-deep
// elastic valid/ready pipeline carrying {res, flags, tag, op}.
//   clk, reset                    : clock, synchronous active-low reset
//   in_valid/in_ready             : input handshake
//   in_databits, a, b, in_op      : operation tag, operands, opcode
//   out_valid/out_ready           : output handshake
//   res, out_databits, out_op     : result, returned tag, opcode of result
//   flags                         : {N, Z, C, V} of result
// in_ready depends only on slot occupancy and out_ready (never on in_valid).
module alu_pipe_stream
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DATABITS = 8,
    parameter int STAGES   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATABITS-1:0] in_databits,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [OP_W-1:0]     in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    res,
    output logic [DATABITS-1:0] out_databits,
    output logic [OP_W-1:0]     out_op,
    output logic [3:0]          flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam int PW  = WIDTH + 4 + DATABITS + OP_W;

    // ---------------- combinational ALU ----------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;   // MSB is the borrow out
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = !diff_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = a << b[SHW-1:0];
            OP_SHR:  alu_res = a >> b[SHW-1:0];
            OP_PASS: alu_res = b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    // ---------------- elastic pipeline ----------------
    // ready_chain[k] : slot k can accept; ready_chain[STAGES] is the consumer.
    logic [STAGES:0]   ready_chain;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] up_valid;
    logic [PW-1:0]     up_data    [STAGES];
    logic [PW-1:0]     stage_data [STAGES];

    assign ready_chain[STAGES] = out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign up_valid[gi] = in_valid;
                assign up_data[gi]  = {alu_res, alu_flags, in_databits, in_op};
            end else begin : g_body
                assign up_valid[gi] = stage_valid[gi-1];
                assign up_data[gi]  = stage_data[gi-1];
            end

            alu_pipe_stage #(
                .PW       (PW),
                .ZERO_RST (gi == STAGES-1)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .up_valid   (up_valid[gi]),
                .up_data    (up_data[gi]),
                .ready      (ready_chain[gi]),
                .down_ready (ready_chain[gi+1]),
                .valid      (stage_valid[gi]),
                .data       (stage_data[gi])
            );
        end
    endgenerate

    assign in_ready  = ready_chain[0];
    assign out_valid = stage_valid[STAGES-1];
    assign {res, flags, out_databits, out_op} = stage_data[STAGES-1];

endmodule

// File: doc/alu_pipe_stream.md
Name: alu_pipe_stream

Overview:
- Parametrised successor to the team's 2-op pipelined ALU unit.
- Generalised in width, tag width and pipeline depth; op set widened to 8 ops with status flags.
- Adds valid/ready streaming handshake with per-stage bubble collapsing, so downstream backpressure stalls the pipe without dropping or duplicating operations.
- Sits between an operand issue queue and a result writeback consumer; driven cycle-by-cycle from the Ruby-side bench.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, power of two)
DATABITS, 8, width of opaque tag carried alongside each operation
STAGES, 3, pipeline depth in register stages (>=1); latency in cycles

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising clk)
in_valid  input  1  upstream presents an operation
in_ready  output  1  block accepts operation this cycle
in_databits  input  DATABITS  tag, returned unchanged with result
a  input  WIDTH  operand A
b  input  WIDTH  operand B
in_op  input  3  opcode
out_valid  output  1  result present at output stage
out_ready  input  1  downstream accepts result this cycle
res  output  WIDTH  result
out_databits  output  DATABITS  tag of result
out_op  output  3  opcode of result
flags  output  4  {N, Z, C, V} of result

Behaviour:
- Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL (a << b[log2(WIDTH)-1:0]), 6 SHR logical, 7 PASS (res=b).
- Result and flags computed combinationally from a, b, in_op and captured into stage 0; stages 1..STAGES-1 only carry {valid, res, flags, tag, op}. Output ports driven from stage STAGES-1 registers.
- Flags: N = res[WIDTH-1]; Z = (res==0); C = carry-out for ADD, NOT borrow for SUB (a>=b unsigned), 0 otherwise; V = signed overflow for ADD/SUB, 0 otherwise.
- Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
- Stage k loads from stage k-1 (or input for k=0) when stage k is empty or stage k itself is advancing. The last stage advances when out_ready=1.
- in_ready = !valid[0] || advance[0]. Bubbles collapse: an empty stage fills even while the output is stalled.
- Latency STAGES cycles with no stall; throughput 1 op/cycle sustained when out_ready held 1.
- in_ready is combinational from out_ready through the advance chain; no combinational path from in_valid to in_ready.
- Stall: while out_valid && !out_ready, res/out_databits/out_op/flags hold stable.
- Full: all STAGES valid and out_ready=0 -> in_ready=0; an offered op is not accepted and not lost (upstream holds).
- Simultaneous: full pipe with out_ready=1 and in_valid=1 -> one op out, one op in, same cycle.
- Reset (reset==0 at clk edge): all valid bits cleared, out_valid=0, res=0, out_databits=0, out_op=0, flags=0. in_ready reads 1 in the first cycle after reset deasserts. Reset mid-stream discards all in-flight ops.
- Data registers of empty stages are don't-care, except the output stage, which is zeroed at reset.

Decomposition:
- Package alu_pipe_pkg: opcode constants (OP_ADD..OP_PASS), flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), width of opcode (3).
- One sub-module alu_pipe_stage: a single valid/data register slot with load/advance logic, parametrised by payload width.
- Top instantiates STAGES copies of alu_pipe_stage via a generate loop, plus the combinational ALU.

Test Plan:
- WIDTH=8, STAGES=3. Reset held low 2 cycles, then released -> out_valid=0, res=0, flags=0, in_ready=1.
- ADD a=0x7F b=0x01 tag=0x5A, out_ready=1 -> 3 cycles later res=0x80, flags N=1 Z=0 C=0 V=1, out_databits=0x5A, out_op=0.
- SUB a=0x05 b=0x05 -> res=0x00, Z=1 C=1 V=0. SHL a=0x81 b=0x09 (shift by 1) -> res=0x02, C=0.
- Stream 6 ops back-to-back with out_ready=0 -> 3 accepted, in_ready=0 on 4th; output holds first result stable. Raise out_ready -> all 6 emerge in order, tags intact, 1 per cycle, none lost or duplicated.
- Full pipe, out_ready=1, in_valid=1 same cycle -> simultaneous accept and emit; occupancy unchanged.
- Assert reset with 2 ops in flight -> next cycle out_valid=0, and no stale result ever appears afterwards.
